// File: rtl/conv_tap_sequencer_pkg.sv
// Shared types and constants for the convolution tap sequencer.
// Build option CONV_RELU_EN clamps negative results to zero.
package conv_tap_sequencer_pkg;

  localparam int DATA_W          = 32;
  localparam int FRAC_BITS       = 16;
  localparam int ACC_W           = 2 * DATA_W + 8;
  localparam int NUM_FILTER_TAPS = 9;
  localparam int TAP_W           = 4;

  typedef logic signed [DATA_W-1:0]   AcclDataType;
  typedef logic signed [2*DATA_W-1:0] ProdT;
  typedef logic signed [ACC_W-1:0]    AccT;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } seq_state_t;

  typedef struct packed {
    AcclDataType data;
    logic        sat;
  } sat_res_t;

  function automatic sat_res_t satScale(input AccT acc);
    AccT      s;
    AccT      maxV;
    AccT      minV;
    sat_res_t r;
    s    = acc >>> FRAC_BITS;
    maxV = AccT'({1'b0, {(DATA_W-1){1'b1}}});
    minV = ~maxV;
    if (s > maxV) begin
      r.data = {1'b0, {(DATA_W-1){1'b1}}};
      r.sat  = 1'b1;
    end else if (s < minV) begin
      r.data = {1'b1, {(DATA_W-1){1'b0}}};
      r.sat  = 1'b1;
    end else begin
      r.data = s[DATA_W-1:0];
      r.sat  = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_mac_stage.sv
// Product/accumulate pipeline with rescale and saturation.
// With CONV_RELU_EN, negative saturated results become zero.
module conv_mac_stage
  import conv_tap_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clrAcc,
  input  logic        rdEn,
  input  logic        rdLast,
  input  AcclDataType coeff,
  input  AcclDataType pixel,
  input  logic        loadRes,
  output logic        lastAcc,
  output AcclDataType result,
  output logic        resultSat
);

  logic     dataVld;
  logic     dataLast;
  logic     prodVld;
  logic     prodLast;
  logic     accLast;
  ProdT     prod;
  AccT      acc;
  sat_res_t satRes;
  sat_res_t finRes;

  always_comb begin
    satRes = satScale(acc);
    finRes = satRes;
`ifdef CONV_RELU_EN
    if (satRes.data[DATA_W-1]) finRes.data = '0;
`endif
  end

  // last flag rides alongside the data so DRAIN knows when acc is final
  always_ff @(posedge clk) begin
    if (rst) begin
      dataVld   <= 1'b0;
      dataLast  <= 1'b0;
      prodVld   <= 1'b0;
      prodLast  <= 1'b0;
      accLast   <= 1'b0;
      prod      <= '0;
      acc       <= '0;
      result    <= '0;
      resultSat <= 1'b0;
    end else begin
      dataVld  <= rdEn;
      dataLast <= rdEn & rdLast;
      prodVld  <= dataVld;
      prodLast <= dataLast;
      accLast  <= prodLast;
      if (dataVld) prod <= ProdT'(coeff) * ProdT'(pixel);
      if (clrAcc) acc <= '0;
      else if (prodVld) acc <= acc + AccT'(prod);
      if (loadRes) begin
        result    <= finRes.data;
        resultSat <= finRes.sat;
      end
    end
  end

  assign lastAcc = accLast;

endmodule

// File: rtl/conv_tap_sequencer.sv
// Tap sequencer FSM driving the MAC stage for one filter window.
// CONV_RELU_EN (see conv_mac_stage) optionally clamps negatives.
module conv_tap_sequencer
  import conv_tap_sequencer_pkg::*;
#(
  parameter int NUM_TAPS = NUM_FILTER_TAPS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_clr_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic [TAP_W-1:0]  tap_addr_o,
  output logic              rd_en_o,
  input  logic [DATA_W-1:0] coeff_i,
  input  logic [DATA_W-1:0] pixel_i,
  output logic [DATA_W-1:0] result_o,
  output logic              result_sat_o,
  output logic              result_valid_o,
  input  logic              result_ready_i
);

  seq_state_t       state;
  seq_state_t       nxt;
  logic [TAP_W-1:0] cnt;
  logic [TAP_W-1:0] cntNxt;
  logic             rstInt;
  logic             lastTap;
  logic             clrAcc;
  logic             loadRes;
  logic             lastAcc;
  AcclDataType      resData;

  assign rstInt  = rst | cmd_clr_i;
  assign lastTap = (cnt == TAP_W'(NUM_TAPS - 1));

  always_ff @(posedge clk) begin
    if (rstInt) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cntNxt;
    end
  end

  always_comb begin
    nxt     = state;
    cntNxt  = cnt;
    clrAcc  = 1'b0;
    loadRes = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          nxt    = ISSUE;
          cntNxt = '0;
          clrAcc = 1'b1;
        end
      end
      ISSUE: begin
        if (lastTap) begin
          nxt    = DRAIN;
          cntNxt = '0;
        end else begin
          cntNxt = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (lastAcc) begin
          nxt     = DONE;
          loadRes = 1'b1;
        end
      end
      DONE: begin
        if (result_ready_i) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign busy_o         = (state != IDLE);
  assign rd_en_o        = (state == ISSUE);
  assign tap_addr_o     = rd_en_o ? cnt : '0;
  assign result_valid_o = (state == DONE);
  assign result_o       = resData;

  conv_mac_stage u_mac (
    .clk      (clk),
    .rst      (rstInt),
    .clrAcc   (clrAcc),
    .rdEn     (rd_en_o),
    .rdLast   (lastTap),
    .coeff    (AcclDataType'(coeff_i)),
    .pixel    (AcclDataType'(pixel_i)),
    .loadRes  (loadRes),
    .lastAcc  (lastAcc),
    .result   (resData),
    .resultSat(result_sat_o)
  );

endmodule

// File: tb/tb_conv_tap_sequencer.sv
// Directed bench for conv_tap_sequencer (9-tap and 1-tap instances).
// Expectations follow CONV_RELU_EN when it is defined.
module tb_conv_tap_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        ready;
  logic        start9, start1;
  logic        busy9, busy1;
  logic [3:0]  addr9, addr1;
  logic        rdEn9, rdEn1;
  logic [31:0] coeff9, pixel9, coeff1, pixel1;
  logic [31:0] res9, res1;
  logic        sat9, sat1;
  logic        valid9, valid1;

  logic [31:0] coefMem [16];
  logic [31:0] pixMem  [16];
  int          tapLog  [$];
  int          nTests = 0;
  int          nFail  = 0;

  always #5 clk = ~clk;

  conv_tap_sequencer #(.NUM_TAPS(9)) u9 (
    .clk(clk), .rst(rst), .cmd_clr_i(clr), .start_i(start9),
    .busy_o(busy9), .tap_addr_o(addr9), .rd_en_o(rdEn9),
    .coeff_i(coeff9), .pixel_i(pixel9), .result_o(res9),
    .result_sat_o(sat9), .result_valid_o(valid9),
    .result_ready_i(ready)
  );

  conv_tap_sequencer #(.NUM_TAPS(1)) u1 (
    .clk(clk), .rst(rst), .cmd_clr_i(clr), .start_i(start1),
    .busy_o(busy1), .tap_addr_o(addr1), .rd_en_o(rdEn1),
    .coeff_i(coeff1), .pixel_i(pixel1), .result_o(res1),
    .result_sat_o(sat1), .result_valid_o(valid1),
    .result_ready_i(ready)
  );

  // buffer model: one-cycle read latency
  always @(posedge clk) begin
    if (rdEn9) begin
      coeff9 <= coefMem[addr9];
      pixel9 <= pixMem[addr9];
    end
    if (rdEn1) begin
      coeff1 <= coefMem[addr1];
      pixel1 <= pixMem[addr1];
    end
  end

  always @(negedge clk) if (rdEn9) tapLog.push_back(int'(addr9));

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [31:0] c, input logic [31:0] p);
    for (int i = 0; i < 16; i++) begin
      coefMem[i] = c;
      pixMem[i]  = p;
    end
  endtask

  task automatic runWin(input bit one, input int expLat,
                        input logic [31:0] expRes, input logic expSat,
                        input string tag);
    int n;
    bit got;
    @(negedge clk);
    if (one) start1 = 1'b1;
    else start9 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start9 = 1'b0;
    n = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clk);
      n++;
      #1;
      got = one ? valid1 : valid9;
    end
    chk({tag, "_lat"}, 64'(n), 64'(expLat));
    chk({tag, "_res"}, 64'(one ? res1 : res9), 64'(expRes));
    chk({tag, "_sat"}, 64'(one ? sat1 : sat9), 64'(expSat));
  endtask

  task automatic ack(input bit one, input string tag);
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    chk({tag, "_idle"}, 64'(one ? busy1 : busy9), 64'd0);
  endtask

  initial begin
    int n;
    int bad;
    rst = 1'b1;
    clr = 1'b0;
    ready = 1'b0;
    start9 = 1'b0;
    start1 = 1'b0;
    fill(32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", 64'(busy9), 64'd0);
    chk("rst_rden", 64'(rdEn9), 64'd0);
    chk("rst_addr", 64'(addr9), 64'd0);
    chk("rst_res", 64'(res9), 64'd0);
    chk("rst_sat", 64'(sat9), 64'd0);
    chk("rst_valid", 64'({valid9, valid1}), 64'd0);

    // 1.0 * (1..9) -> 45.0
    for (int i = 0; i < 16; i++) begin
      coefMem[i] = 32'h0001_0000;
      pixMem[i]  = (i + 1) << 16;
    end
    tapLog.delete();
    runWin(1'b0, 12, 32'h002D_0000, 1'b0, "sum45");
    chk("tap_cnt", 64'(tapLog.size()), 64'd9);
    for (int i = 0; i < 9 && i < tapLog.size(); i++)
      chk($sformatf("tap%0d", i), 64'(tapLog[i]), 64'(i));
    ack(1'b0, "sum45");

    fill(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    runWin(1'b0, 12, 32'h7FFF_FFFF, 1'b1, "satpos");
    ack(1'b0, "satpos");

    fill(32'h7FFF_FFFF, 32'h8000_0001);
`ifdef CONV_RELU_EN
    runWin(1'b0, 12, 32'h0, 1'b1, "satneg");
`else
    runWin(1'b0, 12, 32'h8000_0000, 1'b1, "satneg");
`endif
    ack(1'b0, "satneg");

    // -1.0 * 2.0 * 9 -> -18.0, then hold DONE
    fill(32'hFFFF_0000, 32'h0002_0000);
`ifdef CONV_RELU_EN
    runWin(1'b0, 12, 32'h0, 1'b0, "neg18");
`else
    runWin(1'b0, 12, 32'hFFEE_0000, 1'b0, "neg18");
`endif
    repeat (20) @(posedge clk);
    #1;
    start9 = 1'b1;
    @(posedge clk);
    #1;
    start9 = 1'b0;
    chk("hold_valid", 64'(valid9), 64'd1);
    chk("hold_busy", 64'(busy9), 64'd1);
`ifdef CONV_RELU_EN
    chk("hold_res", 64'(res9), 64'h0);
`else
    chk("hold_res", 64'(res9), 64'hFFEE_0000);
`endif
    ready = 1'b1;
    start9 = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    start9 = 1'b0;
    chk("hs_busy", 64'(busy9), 64'd0);
    chk("hs_valid", 64'(valid9), 64'd0);
    fill(32'h0001_0000, 32'h0001_0000);
    runWin(1'b0, 12, 32'h0009_0000, 1'b0, "fresh");
    ack(1'b0, "fresh");

    // soft clear at tap 4
    fill(32'h0003_0000, 32'h0001_0000);
    @(negedge clk);
    start9 = 1'b1;
    @(posedge clk);
    #1;
    start9 = 1'b0;
    n = 0;
    while (addr9 != 4'd4 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("clr_reach4", 64'(addr9), 64'd4);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("clr_busy", 64'(busy9), 64'd0);
    chk("clr_rden", 64'(rdEn9), 64'd0);
    chk("clr_addr", 64'(addr9), 64'd0);
    bad = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (valid9) bad++;
    end
    chk("clr_novalid", 64'(bad), 64'd0);
    fill(32'h0001_0000, 32'h0001_0000);
    runWin(1'b0, 12, 32'h0009_0000, 1'b0, "postclr");
    ack(1'b0, "postclr");

    // single-tap instance: 3.0 * 5.0
    fill(32'h0003_0000, 32'h0005_0000);
    runWin(1'b1, 4, 32'h000F_0000, 1'b0, "tap1");
    ack(1'b1, "tap1");

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/conv_tap_sequencer.md
Name: conv_tap_sequencer

Overview:
- Sequences one filter-window dot product over the accelerator's coefficient buffer and pixel buffer.
- Issues tap read addresses to both buffers and multiplies the returned coefficient/pixel pairs in a registered pipeline.
- Accumulates the products, then rescales and saturates the sum.
- Presents one 32-bit result per window on a valid/ready handshake toward the bus-facing output register.

Parameters:
- NUM_TAPS, 9, taps per window (legal range 1..16, matching the 16-entry coefficient buffer).
- DATA_W, 32, signed width of coefficient, pixel and result words.
- FRAC_BITS, 16, fixed-point fraction bits; accumulator is arithmetically shifted right by this amount before saturation.
- ACC_W, 72, signed accumulator width: 2*DATA_W plus 8 guard bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cmd_clr_i  in  1  soft clear (bus write to control address 0x00); same effect as rst
- start_i  in  1  begin one window; sampled only in IDLE
- busy_o  out  1  high in every state except IDLE
- tap_addr_o  out  4  tap index to coeff/pixel buffers
- rd_en_o  out  1  read strobe; buffers return data one cycle later
- coeff_i  in  DATA_W  coefficient for the previous cycle's tap_addr_o
- pixel_i  in  DATA_W  pixel for the previous cycle's tap_addr_o
- result_o  out  DATA_W  saturated result
- result_sat_o  out  1  result was clipped
- result_valid_o  out  1  result available
- result_ready_i  in  1  consumer accepts result

Behaviour:
- Reset (rst or cmd_clr_i): state IDLE; busy_o=0, rd_en_o=0, tap_addr_o=0, result_o=0, result_sat_o=0, result_valid_o=0. Accumulator, pipeline valid bits and tap counter are cleared. Reset applies in any state and aborts a window in flight; no result is produced.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE -> ISSUE when start_i=1.
  - ISSUE: rd_en_o=1 and tap_addr_o = counter, which counts 0..NUM_TAPS-1 on consecutive cycles. After the last tap, -> DRAIN.
  - DRAIN: rd_en_o=0. Waits until the last product has been accumulated, then loads the result register -> DONE.
  - DONE: result_valid_o=1 and outputs are held stable. -> IDLE when result_ready_i=1.
- Pipeline:
  - Read data arrives the cycle after the address is issued.
  - Stage P registers the full-width signed product coeff_i*pixel_i.
  - Stage A adds that product, sign-extended to ACC_W, into the accumulator.
  - Valid bits track each stage.
  - The accumulator is zeroed on the IDLE->ISSUE transition.
- Latency: start_i is sampled at edge E0; result_valid_o rises after edge E(NUM_TAPS+3). For NUM_TAPS=9 that is 12 edges.
- Result arithmetic:
  - Compute s = acc >>> FRAC_BITS (arithmetic shift).
  - If s > 2^(DATA_W-1)-1, result = max and result_sat_o=1.
  - If s < -2^(DATA_W-1), result = min and result_sat_o=1.
  - Otherwise result = s[DATA_W-1:0] and result_sat_o=0.
- Boundary conditions:
  - start_i outside IDLE is ignored; it is not queued.
  - start_i in the same cycle as the DONE handshake is ignored; the block is in IDLE the next cycle and accepts start then.
  - result_ready_i outside DONE has no effect.
  - result_valid_o can be held indefinitely; there is no timeout.
  - NUM_TAPS=1: latency is 4 edges.
  - tap_addr_o never exceeds NUM_TAPS-1.
  - rst and cmd_clr_i together: treated as reset.

Optional Feature:
- Macro: CONV_RELU_EN.
- Defined: after saturation, a negative result is forced to 0. result_sat_o still reflects only clipping. Latency is unchanged; the ReLU is applied in the same stage as saturation.
- Undefined: signed results pass through unchanged.

Decomposition:
- Shared package: AcclDataType (DATA_W signed), an ACC_W accumulator typedef, NUM_FILTER_TAPS constant, FRAC_BITS constant, and the seq_state_t enum {IDLE, ISSUE, DRAIN, DONE}.
- One sub-module: conv_mac_stage. It contains the product register, the accumulator, the valid tracking and the shift/saturate (with the CONV_RELU_EN hook).
- The parent holds the FSM and the tap counter.

Test Plan:
- NUM_TAPS=9, FRAC_BITS=16, all coeff=0x00010000 (1.0), pixels 1..9 (integer<<16): start -> result_o=45<<16, valid at edge 12, result_sat_o=0, tap_addr_o sequence 0..8.
- coeff=0x7FFFFFFF, pixel=0x7FFFFFFF for all taps -> result_o=0x7FFFFFFF, result_sat_o=1. Repeat with pixels negated -> 0x80000000, result_sat_o=1; with CONV_RELU_EN -> 0, result_sat_o=1.
- coeff=-1.0 (0xFFFF0000), pixels=2.0 (0x00020000) -> result_o=-18.0 (0xFFEE0000); with CONV_RELU_EN -> 0.
- Hold result_ready_i=0 for 20 cycles after valid, then pulse start_i -> outputs stable, start ignored. Assert ready -> IDLE next cycle; a new start then yields a fresh result with no carry-over.
- Assert cmd_clr_i during ISSUE at tap 4 -> next cycle busy_o=0, rd_en_o=0, result_valid_o never rises. A following start gives the correct result from a zero accumulator.
- NUM_TAPS=1, coeff=3.0, pixel=5.0 -> result_o=15.0 (0x000F0000), valid 4 edges after start.
